// File: rtl/jtag_l2_test.sv
// jtag_l2_test: clk-sampled JTAG TAP giving scan access to a 32-bit L2 memory.
// Define JTAG_L2_IDCODE_EN to build the IDCODE instruction (otherwise code 5'b00010 is BYPASS).
module jtag_l2_test #(
  parameter logic [31:0] IDCODE_VAL = 32'h249511C3,
  parameter int          L2_WORDS   = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic jtag_tck_i,
  input  logic jtag_trst_ni,
  input  logic jtag_tms_i,
  input  logic jtag_tdi_i,
  output logic jtag_tdo_o
);
  localparam int AW = $clog2(L2_WORDS);
`ifdef JTAG_L2_IDCODE_EN
  localparam logic [4:0] IR_RST = 5'b00010;
`else
  localparam logic [4:0] IR_RST = 5'b11111;
`endif
  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PA_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PA_IR, S_EX2_IR, S_UPD_IR
  } tap_e;
  typedef enum logic [1:0] {SEL_BYP, SEL_ID, SEL_ACC, SEL_CFG} sel_e;
  logic [1:0]    r_tck_s, r_tms_s, r_tdi_s, r_trst_s;
  logic          r_tck_d;
  tap_e          r_state, w_next;
  sel_e          w_sel;
  logic [4:0]    r_ir, r_ir_sr;
  logic [64:0]   r_dr, w_cap, w_dr_sh;
  logic [6:0]    w_msb;
  logic [8:0]    r_cfg;
  logic          r_tdo;
  logic [31:0]   r_mem [L2_WORDS];
  logic [31:0]   r_rdata, r_addr;
  logic [AW-1:0] r_ridx, w_idx;
  logic          r_pend;
  logic          w_rise, w_fall, w_tms, w_tdi, w_upd_acc;
  always_ff @(posedge clk_i) begin
    r_tck_s  <= {r_tck_s[0], jtag_tck_i};
    r_tms_s  <= {r_tms_s[0], jtag_tms_i};
    r_tdi_s  <= {r_tdi_s[0], jtag_tdi_i};
    r_trst_s <= {r_trst_s[0], jtag_trst_ni};
    r_tck_d  <= r_tck_s[1];
  end
  assign w_rise = r_tck_s[1] & ~r_tck_d;
  assign w_fall = ~r_tck_s[1] & r_tck_d;
  assign w_tms  = r_tms_s[1];
  assign w_tdi  = r_tdi_s[1];
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TLR:    w_next = w_tms ? S_TLR    : S_RTI;
      S_RTI:    w_next = w_tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: w_next = w_tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: w_next = w_tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  w_next = w_tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: w_next = w_tms ? S_UPD_DR : S_PA_DR;
      S_PA_DR:  w_next = w_tms ? S_EX2_DR : S_PA_DR;
      S_EX2_DR: w_next = w_tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: w_next = w_tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: w_next = w_tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: w_next = w_tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  w_next = w_tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: w_next = w_tms ? S_UPD_IR : S_PA_IR;
      S_PA_IR:  w_next = w_tms ? S_EX2_IR : S_PA_IR;
      S_EX2_IR: w_next = w_tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: w_next = w_tms ? S_SEL_DR : S_RTI;
      default:  w_next = S_TLR;
    endcase
  end
`ifdef JTAG_L2_IDCODE_EN
  assign w_sel = r_ir == 5'b00100 ? SEL_ACC : r_ir == 5'b00110 ? SEL_CFG :
                 r_ir == 5'b00010 ? SEL_ID : SEL_BYP;
`else
  assign w_sel = r_ir == 5'b00100 ? SEL_ACC : r_ir == 5'b00110 ? SEL_CFG : SEL_BYP;
`endif
  // One shared DR shifter; TDI enters at the MSB of the selected register length.
  always_comb begin
    w_msb = w_sel == SEL_ACC ? 7'd64 : w_sel == SEL_CFG ? 7'd8 : w_sel == SEL_ID ? 7'd31 : 7'd0;
    w_cap = w_sel == SEL_ACC ? {1'b0, r_addr, r_rdata} :
            w_sel == SEL_CFG ? {56'd0, r_cfg} :
            w_sel == SEL_ID  ? {33'd0, IDCODE_VAL} : 65'd0;
    w_dr_sh = {1'b0, r_dr[64:1]};
    w_dr_sh[w_msb] = w_tdi;
  end
  always_ff @(posedge clk_i) begin
    if (!r_trst_s[1] || r_state == S_TLR) begin
      r_ir    <= IR_RST;
      r_ir_sr <= '0;
      r_dr    <= '0;
      r_cfg   <= '0;
      r_tdo   <= 1'b0;
    end else begin
      if (w_rise) begin
        r_ir_sr <= r_state == S_CAP_IR ? 5'b00001 : r_state == S_SH_IR ? {w_tdi, r_ir_sr[4:1]} : r_ir_sr;
        r_dr    <= r_state == S_CAP_DR ? w_cap : r_state == S_SH_DR ? w_dr_sh : r_dr;
      end
      if (w_fall && r_state == S_UPD_IR) r_ir <= r_ir_sr;
      if (w_fall && r_state == S_UPD_DR && w_sel == SEL_CFG) r_cfg <= r_dr[8:0];
      r_tdo <= !(r_state == S_SH_DR || r_state == S_SH_IR) ? 1'b0 :
               !w_fall ? r_tdo : r_state == S_SH_DR ? r_dr[0] : r_ir_sr[0];
    end
    r_state <= !r_trst_s[1] ? S_TLR : w_rise ? w_next : r_state;
  end
  assign jtag_tdo_o = r_tdo;
  assign w_idx      = r_dr[AW+33:34];
  assign w_upd_acc  = w_fall && r_state == S_UPD_DR && w_sel == SEL_ACC && !rst_i;
  always_ff @(posedge clk_i) begin
    if (w_upd_acc && r_dr[64]) r_mem[w_idx] <= r_dr[31:0];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
      r_addr  <= '0;
      r_ridx  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= w_upd_acc & ~r_dr[64];
      if (r_pend) r_rdata <= r_mem[r_ridx];
      if (w_upd_acc) begin
        r_addr <= r_dr[63:32];
        r_ridx <= w_idx;
      end
    end
  end
endmodule

// File: tb/tb_jtag_l2_test.sv
// tb_jtag_l2_test: directed JTAG scans (table plus hand sequences) against jtag_l2_test.
module tb_jtag_l2_test;
  logic clk = 1'b0, rst = 1'b1, tck = 1'b0, trst_n = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic tdo;
  int   n_chk = 0, n_fail = 0;
  jtag_l2_test dut (
    .clk_i(clk), .rst_i(rst), .jtag_tck_i(tck), .jtag_trst_ni(trst_n),
    .jtag_tms_i(tms), .jtag_tdi_i(tdi), .jtag_tdo_o(tdo)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0]  ir;
    int          n;
    logic        rst;
    logic [64:0] din;
    logic [64:0] exp;
    string       name;
  } vec_t;
  vec_t vecs [15];
  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tck_cyc(input logic m, input logic d, output logic t);
    tck = 1'b0;
    tms = m;
    tdi = d;
    repeat (8) @(negedge clk);
    t = tdo;
    tck = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task automatic tap_reset();
    logic t;
    repeat (5) tck_cyc(1'b1, 1'b0, t);
    tck_cyc(1'b0, 1'b0, t);
  endtask
  task automatic scan_ir(input logic [4:0] ir, output logic [4:0] dout);
    logic t;
    tck_cyc(1'b1, 1'b0, t);
    tck_cyc(1'b1, 1'b0, t);
    tck_cyc(1'b0, 1'b0, t);
    tck_cyc(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      tck_cyc(i == 4, ir[i], t);
      dout[i] = t;
    end
    tck_cyc(1'b1, 1'b0, t);
    tck_cyc(1'b0, 1'b0, t);
  endtask
  task automatic scan_dr(input logic [64:0] din, input int n, output logic [64:0] dout);
    logic t;
    dout = '0;
    tck_cyc(1'b1, 1'b0, t);
    tck_cyc(1'b0, 1'b0, t);
    tck_cyc(1'b0, 1'b0, t);
    for (int i = 0; i < n; i++) begin
      tck_cyc(i == n - 1, din[i], t);
      dout[i] = t;
    end
    tck_cyc(1'b1, 1'b0, t);
    tck_cyc(1'b0, 1'b0, t);
  endtask
  initial begin
    logic [64:0] dout, mask;
    logic [4:0]  irout;
    logic        t;
    vecs[0]  = '{5'h1F, 9,  1'b0, 65'h0A5, 65'h14A, "bypass_a5"};
`ifdef JTAG_L2_IDCODE_EN
    vecs[1]  = '{5'h02, 2,  1'b0, 65'h3, 65'h3, "code_02"};
`else
    vecs[1]  = '{5'h02, 2,  1'b0, 65'h3, 65'h2, "code_02"};
`endif
    vecs[2]  = '{5'h0A, 3,  1'b0, 65'h5, 65'h2, "ir_unknown"};
    vecs[3]  = '{5'h06, 9,  1'b1, 65'h002, 65'h000, "cfg_rst_wr"};
    vecs[4]  = '{5'h06, 9,  1'b1, 65'h000, 65'h002, "cfg_rst_rd"};
    vecs[5]  = '{5'h06, 9,  1'b0, 65'h1A5, 65'h000, "cfg_wr"};
    vecs[6]  = '{5'h06, 9,  1'b0, 65'h000, 65'h1A5, "cfg_rd"};
    vecs[7]  = '{5'h04, 65, 1'b0, {1'b1, 32'h0, 32'hABBAABBA}, 65'h0, "acc_wr"};
    vecs[8]  = '{5'h04, 65, 1'b0, {1'b0, 32'h0, 32'h0}, 65'h0, "acc_rd1"};
    vecs[9]  = '{5'h04, 65, 1'b0, {1'b0, 32'h400, 32'h0}, {1'b0, 32'h0, 32'hABBAABBA}, "acc_rd2"};
    vecs[10] = '{5'h04, 65, 1'b0, {1'b1, 32'h404, 32'h12345678}, {1'b0, 32'h400, 32'hABBAABBA}, "acc_wrap"};
    vecs[11] = '{5'h04, 65, 1'b1, {1'b1, 32'h4, 32'hDEADBEEF}, 65'h0, "acc_rst_wr"};
    vecs[12] = '{5'h04, 65, 1'b0, {1'b0, 32'h4, 32'h0}, 65'h0, "acc_rd3"};
    vecs[13] = '{5'h04, 65, 1'b0, {1'b0, 32'h0, 32'h0}, {1'b0, 32'h4, 32'h12345678}, "acc_mem_kept"};
    vecs[14] = '{5'h04, 65, 1'b0, {1'b0, 32'h0, 32'h0}, {1'b0, 32'h0, 32'hABBAABBA}, "acc_idx0"};
    repeat (10) @(negedge clk);
    check("trst_tdo", {64'd0, tdo}, 65'd0);
    trst_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    tap_reset();
    check("rti_tdo", {64'd0, tdo}, 65'd0);
`ifdef JTAG_L2_IDCODE_EN
    scan_dr(65'h0, 32, dout);
    check("reset_idcode", dout, 65'h249511C3);
`else
    scan_dr(65'h0, 1, dout);
    check("reset_bypass", dout, 65'h0);
`endif
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      scan_ir(vecs[i].ir, irout);
      check({vecs[i].name, "_ircap"}, {60'd0, irout}, 65'h1);
      scan_dr(vecs[i].din, vecs[i].n, dout);
      mask = vecs[i].n == 65 ? '1 : (65'd1 << vecs[i].n) - 65'd1;
      check(vecs[i].name, dout & mask, vecs[i].exp);
    end
    rst = 1'b0;
    scan_ir(5'h06, irout);
    scan_dr(65'h0AB, 9, dout);
    tck_cyc(1'b1, 1'b0, t);
    tck_cyc(1'b0, 1'b0, t);
    tck_cyc(1'b0, 1'b0, t);
    repeat (5) tck_cyc(1'b1, 1'b1, t);
    check("tlr_tdo", {64'd0, tdo}, 65'd0);
    tck_cyc(1'b0, 1'b0, t);
    scan_ir(5'h06, irout);
    scan_dr(65'h0, 9, dout);
    check("tlr_cfg", dout, 65'h0);
    scan_dr(65'h155, 9, dout);
    scan_dr(65'h0, 9, dout);
    check("cfg_155", dout, 65'h155);
    trst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("trst2_tdo", {64'd0, tdo}, 65'd0);
    trst_n = 1'b1;
    repeat (4) @(negedge clk);
    tck_cyc(1'b0, 1'b0, t);
    scan_ir(5'h06, irout);
    scan_dr(65'h0, 9, dout);
    check("trst_cfg", dout, 65'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jtag_l2_test.md
JTAG_L2_TEST -- requirements
Module: jtag_l2_test

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter IDCODE_VAL, default 32'h249511C3: value returned by IDCODE; bit 0 SHALL be 1.
REQ-003 Parameter L2_WORDS, default 256: depth of the internal 32-bit L2 memory, power of two.
REQ-004 clk_i  in  1  sole system clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset of the L2 access path.
REQ-006 jtag_tck_i  in  1  JTAG TCK, sampled as data in clk_i.
REQ-007 jtag_trst_ni  in  1  JTAG TRST, active low, sampled in clk_i.
REQ-008 jtag_tms_i  in  1  JTAG TMS.
REQ-009 jtag_tdi_i  in  1  JTAG TDI.
REQ-010 jtag_tdo_o  out  1  JTAG TDO, registered.

Function
REQ-011 tck, tms, tdi and trst_ni SHALL pass through 2-flop synchronizers; a tck rise or fall is detected from the synchronized value; clk_i SHALL be at least 8x tck.
REQ-012 TAP: standard 16-state IEEE 1149.1 FSM; it advances only on a detected tck rise, using the synchronized tms.
REQ-013 Instruction register: 5 bits, shifted LSB first; Capture-IR loads 5'b00001; the instruction is latched at Update-IR.
REQ-014 Instruction decode: IDCODE=5'b00010, ACCESS=5'b00100, CONFREG=5'b00110, BYPASS=5'b11111; any other code selects BYPASS.
REQ-015 BYPASS DR: 1 bit; Capture-DR loads 0, so TDI appears at TDO delayed by one tck.
REQ-016 IDCODE DR: 32 bits; Capture-DR loads IDCODE_VAL.
REQ-017 CONFREG DR: 9 bits; Capture-DR loads the current confreg; Update-DR writes the shifted value; the confreg reads back its previous contents.
REQ-018 ACCESS DR: 65 bits, shifted LSB first: [31:0] data, [63:32] addr, [64] we.
REQ-019 ACCESS Update-DR: memory index = addr[log2(L2_WORDS)+1:2].
REQ-020 ACCESS write (we=1): writes data to the indexed word in the same clk_i cycle.
REQ-021 ACCESS read (we=0): latches mem[index] into rdata_q one clk_i cycle after Update-DR.
REQ-022 ACCESS Capture-DR: loads {1'b0, last addr, rdata_q}; a read therefore needs two scans, and rdata arrives in bits [31:0] of the second scan.
REQ-023 Out-of-range address bits SHALL be ignored, so the index wraps modulo L2_WORDS.
REQ-024 Shift: jtag_tdo_o takes the selected register LSB on the first detected tck fall after entering Shift-IR/DR, and each following fall after a shift; it is 0 outside the Shift states.
REQ-025 A write followed by a read at the same address SHALL return the written data.
REQ-026 Update-DR of ACCESS while rst_i=1 SHALL be ignored.

Reset
REQ-027 rst_i=1: rdata_q=0 and any pending read is cancelled; the TAP, IR and confreg SHALL be unaffected.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Synchronized trst_ni=0, or the Test-Logic-Reset state, SHALL reset the TAP: state=TLR, IR=IDCODE (BYPASS without the macro), confreg=9'h000, all DR shift registers=0, jtag_tdo_o=0.
REQ-030 Five tck cycles with tms=1 SHALL reach TLR from any state.

Configuration
REQ-031 Macro JTAG_L2_IDCODE_EN defined: the IDCODE instruction is implemented and TLR selects IDCODE.
REQ-032 Macro JTAG_L2_IDCODE_EN undefined: code 5'b00010 decodes to BYPASS, TLR selects BYPASS, and no IDCODE register is built.

Verification
REQ-033 trst_ni low, then 5 tck with tms=1 -> TAP in TLR, jtag_tdo_o=0.
REQ-034 IR=BYPASS, shift 8'hA5 -> TDO returns 0 followed by 8'hA5 LSB first, one-bit delay.
REQ-035 JTAG_L2_IDCODE_EN defined, scan DR after reset -> 32'h249511C3; macro undefined -> single 0 bypass bit.
REQ-036 CONFREG scan of 9'h002 with rst_i=1 -> shifted-out value 9'h000; a second scan reads 9'h002.
REQ-037 rst_i=0, ACCESS scan {1,32'h0,32'hABBAABBA}, then {0,32'h0,x}, then a third scan -> third scan bits [31:0]=32'hABBAABBA.
REQ-038 ACCESS write at addr 32'h400 with L2_WORDS=256 -> the data is readable at addr 32'h0 (wrap); a write attempted while rst_i=1 leaves memory unchanged.
